// File: rtl/load_store_unit.sv
// Memory-access stage: turns the sequencer's load/store enable into one req/ack
// transaction on the data-memory bus and returns a one-cycle ls_done pulse.
// Optional LSU_TIMEOUT_EN aborts a request that gets no mem_ack within TIMEOUT_CYCLES.
module load_store_unit #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        en_ls,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] d_out,
    output logic              ls_done,
    output logic              busy,
    output logic              ls_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_HOLD
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t              state_q,     state_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   d_out_q,     d_out_d;
    logic                ls_done_q,   ls_done_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                ls_err_q,    ls_err_d;
`endif

    logic is_op;
    assign is_op = en_ls[0] ^ en_ls[1];

    // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_out_d     = d_out_q;
        ls_done_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        ls_err_d    = ls_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (is_op) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = en_ls[1];
                    mem_addr_d  = addr;
                    mem_wdata_d = st_data;
                    state_d     = S_REQ;
`ifdef LSU_TIMEOUT_EN
                    cnt_d       = '0;
                    ls_err_d    = 1'b0;
`endif
                end
            end

            S_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    ls_done_d = 1'b1;
                    state_d   = S_DONE;
                    if (!mem_we_q) begin
                        d_out_d = mem_rdata;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abort still pulses ls_done so the sequencer leaves execute.
                    mem_req_d = 1'b0;
                    ls_done_d = 1'b1;
                    ls_err_d  = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            S_DONE: begin
                state_d = S_HOLD;
            end

            S_HOLD: begin
                // The enable is a level; wait for it to drop so one request is one transaction.
                if (en_ls == 2'b00) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            d_out_q     <= '0;
            ls_done_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            ls_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_out_q     <= d_out_d;
            ls_done_q   <= ls_done_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            ls_err_q    <= ls_err_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign d_out     = d_out_q;
    assign ls_done   = ls_done_q;
    assign busy      = (state_q != S_IDLE);

`ifdef LSU_TIMEOUT_EN
    assign ls_err = ls_err_q;
`else
    assign ls_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected transactions,
// a negedge monitor checks the bus while mem_req is high and pops on every ls_done.
module tb_load_store_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int TO     = 4;

    logic              clk;
    logic              reset;
    logic [1:0]        en_ls;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] d_out;
    logic              ls_done;
    logic              busy;
    logic              ls_err;

    load_store_unit #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en_ls    (en_ls),
        .addr     (addr),
        .st_data  (st_data),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .d_out    (d_out),
        .ls_done  (ls_done),
        .busy     (busy),
        .ls_err   (ls_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] dout;
        logic              err;
    } exp_t;

    exp_t              sb[$];
    int                checks   = 0;
    int                failures = 0;
    int                done_cnt = 0;
    logic [DATA_W-1:0] exp_dout = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: bus checked against the head transaction, which retires on ls_done.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_req) begin
                if (sb.size() == 0) begin
                    check("req_unexpected", {31'b0, mem_req}, 32'd0);
                end else begin
                    check("bus_we",    {31'b0, mem_we}, {31'b0, sb[0].we});
                    check("bus_addr",  32'(mem_addr),   32'(sb[0].addr));
                    check("bus_wdata", 32'(mem_wdata),  32'(sb[0].wdata));
                end
            end
            if (ls_done) begin
                exp_t e;
                done_cnt++;
                if (sb.size() == 0) begin
                    check("done_unexpected", {31'b0, ls_done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_dout", 32'(d_out),       32'(e.dout));
                    check("done_err",  {31'b0, ls_err}, {31'b0, e.err});
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rdata,
                          input int ack_cycle, input int exp_req, input logic exp_err,
                          input int hold);
        exp_t e;
        int   req_cnt     = 0;
        int   done_before = done_cnt;
        if (op == 2'b01 && !exp_err) exp_dout = rdata;
        e.we = op[1]; e.addr = a; e.wdata = d; e.dout = exp_dout; e.err = exp_err;
        sb.push_back(e);
        en_ls = op; addr = a; st_data = d; mem_ack = 1'b0; mem_rdata = rdata;
        @(posedge clk); #1;
        addr = ~a; st_data = ~d;
        for (int k = 1; k <= 40; k++) begin
            mem_ack = (k == ack_cycle);
            @(negedge clk);
            if (!mem_req) break;
            req_cnt++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        check("req_cycles", 32'(req_cnt), 32'(exp_req));
        check("done_pulse", {31'b0, ls_done}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_busy", {31'b0, busy},    32'd1);
            check("hold_req",  {31'b0, mem_req}, 32'd0);
        end
        en_ls = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_busy",  {31'b0, busy}, 32'd0);
        check("done_count", 32'(done_cnt - done_before), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   done_before;
        reset = 1'b0; en_ls = 2'b01; addr = 8'h3C; st_data = 16'h0;
        mem_rdata = 16'h0; mem_ack = 1'b0;

        // Reset held two cycles with a load requested.
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst_req",  {31'b0, mem_req}, 32'd0);
        check("rst_done", {31'b0, ls_done}, 32'd0);
        check("rst_dout", 32'(d_out),       32'd0);
        check("rst_busy", {31'b0, busy},    32'd0);
        check("rst_err",  {31'b0, ls_err},  32'd0);
        reset = 1'b1; en_ls = 2'b00;

        // 11 is a no-op.
        en_ls = 2'b11;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("nop_busy", {31'b0, busy},    32'd0);
        check("nop_req",  {31'b0, mem_req}, 32'd0);
        en_ls = 2'b00;
        @(posedge clk); #1;

        // Zero-wait load, enable held 4 cycles after completion.
        run_op(2'b01, 8'h3C, 16'h0000, 16'hBEEF, 1, 1, 1'b0, 4);
        // Store with ack on the third request cycle; d_out must keep BEEF.
        run_op(2'b10, 8'h05, 16'h1234, 16'hDEAD, 3, 3, 1'b0, 1);
        // Boundary address/data patterns.
        run_op(2'b01, 8'hFF, 16'h5A5A, 16'h0001, 2, 2, 1'b0, 1);
        run_op(2'b10, 8'h00, 16'hFFFF, 16'hC0DE, 1, 1, 1'b0, 2);
        run_op(2'b01, 8'h80, 16'h0000, 16'hFFFF, 5, 5, 1'b0, 1);

`ifdef LSU_TIMEOUT_EN
        run_op(2'b01, 8'h44, 16'h0000, 16'hAAAA, 0, TO, 1'b1, 1);
        check("err_held", {31'b0, ls_err}, 32'd1);
        run_op(2'b10, 8'h45, 16'h7777, 16'hAAAA, 1, 1, 1'b0, 1);
`endif

        // Reset during a pending load; a later ack must be ignored.
        done_before = done_cnt;
        e.we = 1'b0; e.addr = 8'h77; e.wdata = 16'h2222; e.dout = 16'h0; e.err = 1'b0;
        sb.push_back(e);
        en_ls = 2'b01; addr = 8'h77; st_data = 16'h2222; mem_rdata = 16'h5555;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_req_before", {31'b0, mem_req}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        exp_dout = '0;
        @(negedge clk);
        check("mid_req_after", {31'b0, mem_req}, 32'd0);
        check("mid_busy",      {31'b0, busy},    32'd0);
        check("mid_dout",      32'(d_out),       32'(exp_dout));
        reset = 1'b1; en_ls = 2'b00; mem_ack = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ack = 1'b0;
        @(negedge clk);
        check("post_req",  {31'b0, mem_req}, 32'd0);
        check("post_dout", 32'(d_out),       32'd0);
        check("post_done", 32'(done_cnt - done_before), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
